// File: rtl/mul_share_arbiter.sv
// Shares one multi-cycle signed 4x4 multiplier among four requesters; round-robin grant, or lowest index wins when MUL_ARB_FIXED_PRIO_EN is defined.
// Latency: req sampled in IDLE cycle c -> mul_start in c+1, done in c+RESULT_DELAY+2; requests arriving while busy are ignored, not queued.
module mul_share_arbiter #(
    parameter int NREQ         = 4,
    parameter int RESULT_DELAY = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req,
    input  logic [4*NREQ-1:0] a_in,
    input  logic [4*NREQ-1:0] b_in,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   done,
    output logic [7:0]        result,
    output logic              busy,
    output logic              mul_start,
    output logic [3:0]        mul_a,
    output logic [3:0]        mul_b,
    input  logic [7:0]        mul_p
);
    localparam int IDXW = $clog2(NREQ);
    localparam int CNTW = (RESULT_DELAY > 2) ? $clog2(RESULT_DELAY) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t          state;
    logic [IDXW-1:0] win_idx;
    logic [3:0]      op_a;
    logic [3:0]      op_b;
    logic [CNTW-1:0] cnt;

`ifndef MUL_ARB_FIXED_PRIO_EN
    logic [IDXW-1:0] ptr;
`endif

    // Winner among current requests; only meaningful when req is nonzero.
    logic [IDXW-1:0] win_idx_c;
`ifdef MUL_ARB_FIXED_PRIO_EN
    always_comb begin
        win_idx_c = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[i]) win_idx_c = IDXW'(i);
        end
    end
`else
    logic [IDXW-1:0] cand;
    always_comb begin
        win_idx_c = '0;
        cand      = '0;
        // Descending scan so the candidate closest to ptr is assigned last and wins.
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand = ptr + IDXW'(k);
            if (req[cand]) win_idx_c = cand;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            win_idx   <= '0;
            op_a      <= '0;
            op_b      <= '0;
            cnt       <= '0;
            gnt       <= '0;
            done      <= '0;
            result    <= '0;
            mul_start <= 1'b0;
`ifndef MUL_ARB_FIXED_PRIO_EN
            ptr       <= '0;
`endif
        end else begin
            mul_start <= 1'b0;
            done      <= '0;
            case (state)
                IDLE: begin
                    if (|req) begin
                        win_idx   <= win_idx_c;
                        op_a      <= a_in[4*win_idx_c +: 4];
                        op_b      <= b_in[4*win_idx_c +: 4];
                        gnt       <= NREQ'(1) << win_idx_c;
                        mul_start <= 1'b1;
`ifndef MUL_ARB_FIXED_PRIO_EN
                        ptr       <= win_idx_c + IDXW'(1);
`endif
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    cnt   <= CNTW'(RESULT_DELAY - 1);
                    state <= WAIT;
                end
                WAIT: begin
                    // cnt reaches zero in the cycle whose closing edge is RESULT_DELAY after ISSUE.
                    if (cnt == '0) begin
                        result <= mul_p;
                        done   <= NREQ'(1) << win_idx;
                        state  <= DONE;
                    end else begin
                        cnt <= cnt - CNTW'(1);
                    end
                end
                DONE: begin
                    gnt   <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Operands stay in op_a/op_b until the next grant, so the multiplier sees stable inputs.
    assign mul_a = op_a;
    assign mul_b = op_b;
    assign busy  = (state != IDLE);

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Bench for mul_share_arbiter: transaction-timeline reference model plus a latency-exact multiplier model.
module tb_mul_share_arbiter;
    localparam int D = 6;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req = '0;
    logic [15:0] a_in = '0;
    logic [15:0] b_in = '0;
    logic [3:0]  gnt, done;
    logic [7:0]  result;
    logic        busy, mul_start;
    logic [3:0]  mul_a, mul_b;
    logic [7:0]  mul_p = '0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mul_share_arbiter #(.NREQ(4), .RESULT_DELAY(D)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .a_in(a_in), .b_in(b_in),
        .gnt(gnt), .done(done), .result(result), .busy(busy),
        .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p)
    );

    function automatic logic [7:0] prod8(input logic [3:0] a, input logic [3:0] b);
        int x;
        int y;
        x = $signed(a);
        y = $signed(b);
        return 8'(x * y);
    endfunction

    // Multiplier: product valid only in cycle t+D after the mul_start cycle t, garbage otherwise.
    int   mk = -1;
    logic mrs;
    always @(posedge clk) begin
        mrs = rst_n;
        #1;
        if (!mrs) mk = -1;
        else if (mul_start) mk = 0;
        else if (mk >= 0 && mk < 1000) mk++;
        if (mk == D) mul_p = prod8(mul_a, mul_b);
        else mul_p = 8'($urandom);
    end

    // Reference model state: one operation at a time, positioned on an absolute cycle timeline.
    int         cyc = 0;
    int         free_at = 0;
    int         op_w = 0;
    int         op_issue = 0;
    int         op_done = 0;
    bit         op_valid = 0;
    int         ptr_m = 0;
    logic [3:0] m_a = '0;
    logic [3:0] m_b = '0;
    logic [7:0] m_res = '0;
    logic [3:0] e_gnt, e_done, e_a, e_b;
    logic       e_busy, e_start;
    logic [7:0] e_res;

    function automatic int pick(input logic [3:0] r, input int p);
`ifdef MUL_ARB_FIXED_PRIO_EN
        for (int i = 0; i < 4; i++) if (r[i]) return i;
`else
        for (int k = 0; k < 4; k++) if (r[(p + k) % 4]) return (p + k) % 4;
`endif
        return -1;
    endfunction

    task automatic tick();
        bit act;
        @(posedge clk);
        if (!rst_n) begin
            op_valid = 0; free_at = cyc + 1; ptr_m = 0; m_res = '0; m_a = '0; m_b = '0;
        end else begin
            if (op_valid && cyc == op_done - 1) m_res = prod8(m_a, m_b);
            if (cyc >= free_at && req != 4'b0) begin
                op_w = pick(req, ptr_m);
                op_valid = 1; op_issue = cyc + 1; op_done = cyc + 2 + D; free_at = cyc + 3 + D;
                m_a = a_in[4*op_w +: 4];
                m_b = b_in[4*op_w +: 4];
                ptr_m = (op_w + 1) % 4;
            end
        end
        cyc++;
        #1;
        act     = op_valid && cyc >= op_issue && cyc <= op_done;
        e_gnt   = act ? 4'(1 << op_w) : 4'b0;
        e_busy  = act;
        e_start = op_valid && cyc == op_issue;
        e_done  = (op_valid && cyc == op_done) ? 4'(1 << op_w) : 4'b0;
        e_res   = m_res;
        e_a     = m_a;
        e_b     = m_b;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req = 4'b1111; a_in = 16'($urandom); b_in = 16'($urandom);
        repeat (3) tick();
        checks++; if (gnt !== 4'b0) begin errors++; $display("FAIL reset_gnt got %b want 0000", gnt); end
        checks++; if (done !== 4'b0) begin errors++; $display("FAIL reset_done got %b want 0000", done); end
        checks++; if (result !== 8'h00) begin errors++; $display("FAIL reset_result got %h want 00", result); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (mul_start !== 1'b0) begin errors++; $display("FAIL reset_mul_start got %b want 0", mul_start); end
        checks++; if ({mul_a, mul_b} !== 8'h00) begin errors++; $display("FAIL reset_operands got %h/%h want 0/0", mul_a, mul_b); end
        req = 4'b0;
        rst_n = 1'b1;
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy got %b want 0", busy); end
    endtask

    task automatic test_single();
        req = 4'b0001; a_in = {12'($urandom), 4'd3}; b_in = {12'($urandom), 4'hE};
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k == 1) req = 4'b0000;
            checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL single_gnt c+%0d got %b want 0001", k, gnt); end
            checks++; if (mul_start !== (k == 1)) begin errors++; $display("FAIL single_start c+%0d got %b want %b", k, mul_start, k == 1); end
            checks++; if ({mul_a, mul_b} !== 8'h3E) begin errors++; $display("FAIL single_operands c+%0d got %h/%h want 3/e", k, mul_a, mul_b); end
            checks++; if (done !== ((k == 8) ? 4'b0001 : 4'b0000)) begin errors++; $display("FAIL single_done c+%0d got %b", k, done); end
        end
        checks++; if (result !== 8'hFA) begin errors++; $display("FAIL single_result got %h want fa", result); end
        tick();
        checks++; if (gnt !== 4'b0 || busy !== 1'b0) begin errors++; $display("FAIL single_idle gnt %b busy %b want 0000 0", gnt, busy); end
        checks++; if (result !== 8'hFA) begin errors++; $display("FAIL single_result_hold got %h want fa", result); end
    endtask

    task automatic test_round_robin();
        int np = 0;
        int c;
        int idx[5];
        int at[5];
        int want;
        rst_n = 1'b0; req = 4'b1111; a_in = 16'($urandom); b_in = 16'($urandom);
        repeat (2) tick();
        rst_n = 1'b1;
        c = cyc;
        for (int k = 0; k < 60 && np < 5; k++) begin
            tick();
            checks++; if (done !== e_done || gnt !== e_gnt) begin errors++; $display("FAIL rr_model cyc %0d done %b gnt %b want %b %b", cyc, done, gnt, e_done, e_gnt); end
            if (done != 4'b0) begin idx[np] = $clog2(done); at[np] = cyc; np++; end
        end
        checks++; if (np != 5) begin errors++; $display("FAIL rr_pulse_count got %0d want 5", np); end
        for (int i = 0; i < np; i++) begin
`ifdef MUL_ARB_FIXED_PRIO_EN
            want = 0;
`else
            want = i % 4;
`endif
            checks++; if (idx[i] != want) begin errors++; $display("FAIL rr_order pulse %0d got %0d want %0d", i, idx[i], want); end
            checks++; if (at[i] != c + 8 + 9 * i) begin errors++; $display("FAIL rr_spacing pulse %0d at %0d want %0d", i, at[i] - c, 8 + 9 * i); end
        end
    endtask

    task automatic test_wrap_around();
        int np = 0;
        int idx[2];
        int want;
        rst_n = 1'b0; req = 4'b0;
        tick();
        rst_n = 1'b1; req = 4'b0100;
        tick();
        req = 4'b0000;
        repeat (8) tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wrap_setup_busy got %b want 0", busy); end
        req = 4'b0101;
        for (int k = 0; k < 30 && np < 2; k++) begin
            tick();
            if (done != 4'b0) begin idx[np] = $clog2(done); np++; end
        end
        req = 4'b0000;
        checks++; if (np != 2) begin errors++; $display("FAIL wrap_count got %0d want 2", np); end
        for (int i = 0; i < np; i++) begin
`ifdef MUL_ARB_FIXED_PRIO_EN
            want = 0;
`else
            want = (i == 0) ? 0 : 2;
`endif
            checks++; if (idx[i] != want) begin errors++; $display("FAIL wrap_order %0d got %0d want %0d", i, idx[i], want); end
        end
        repeat (9) tick();
    endtask

    task automatic test_request_drop();
        req = 4'b0010; a_in = 16'($urandom); b_in = 16'($urandom);
        tick();
        tick();
        req = 4'b0000;
        repeat (6) tick();
        checks++; if (done !== 4'b0010) begin errors++; $display("FAIL drop_done got %b want 0010", done); end
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++; if (busy !== 1'b0 || gnt !== 4'b0) begin errors++; $display("FAIL drop_regrant busy %b gnt %b want 0 0000", busy, gnt); end
        end
    endtask

    task automatic test_operand_hold();
        logic [3:0] bv;
        bv = 4'($urandom_range(1, 7));
        req = 4'b0001; a_in = {12'($urandom), 4'd5}; b_in = {12'($urandom), bv};
        tick();
        req = 4'b0000;
        tick();
        a_in[3:0] = 4'h9;
        for (int k = 2; k <= 8; k++) begin
            checks++; if (mul_a !== 4'd5 || mul_b !== bv) begin errors++; $display("FAIL hold_operands c+%0d got %h/%h want 5/%h", k, mul_a, mul_b, bv); end
            if (k < 8) tick();
        end
        checks++; if (result !== prod8(4'd5, bv)) begin errors++; $display("FAIL hold_result got %h want %h", result, prod8(4'd5, bv)); end
        tick();
    endtask

    task automatic test_reset_mid_op();
        req = 4'b1000; a_in = 16'($urandom); b_in = 16'($urandom);
        tick();
        req = 4'b0000;
        repeat (3) tick();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midrst_busy_before got %b want 1", busy); end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b want 0", busy); end
        checks++; if (result !== 8'h00) begin errors++; $display("FAIL midrst_result got %h want 00", result); end
        checks++; if (mul_start !== 1'b0 || gnt !== 4'b0) begin errors++; $display("FAIL midrst_start_gnt got %b %b want 0 0000", mul_start, gnt); end
        for (int k = 0; k < 6; k++) begin
            checks++; if (done !== 4'b0) begin errors++; $display("FAIL midrst_done got %b want 0000", done); end
            tick();
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 1500; k++) begin
            req   = ($urandom_range(0, 9) < 3) ? 4'b0 : 4'($urandom);
            a_in  = 16'($urandom);
            b_in  = 16'($urandom);
            rst_n = ($urandom_range(0, 99) != 0);
            tick();
            checks++; if (gnt !== e_gnt) begin errors++; $display("FAIL rand_gnt cyc %0d got %b want %b", cyc, gnt, e_gnt); end
            checks++; if (done !== e_done) begin errors++; $display("FAIL rand_done cyc %0d got %b want %b", cyc, done, e_done); end
            checks++; if (busy !== e_busy) begin errors++; $display("FAIL rand_busy cyc %0d got %b want %b", cyc, busy, e_busy); end
            checks++; if (mul_start !== e_start) begin errors++; $display("FAIL rand_start cyc %0d got %b want %b", cyc, mul_start, e_start); end
            checks++; if (result !== e_res) begin errors++; $display("FAIL rand_result cyc %0d got %h want %h", cyc, result, e_res); end
            checks++; if (mul_a !== e_a || mul_b !== e_b) begin errors++; $display("FAIL rand_operands cyc %0d got %h/%h want %h/%h", cyc, mul_a, mul_b, e_a, e_b); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_wrap_around();
        test_request_drop();
        test_operand_hold();
        test_reset_mid_op();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "watchdog");
    end
endmodule
